rdid_ctrl: RTL

//  SPI master that issues the JEDEC Read-ID command (RDID) to the serial flash
//  and captures the returned ID bytes. It sits directly downstream of

---
 rtl/rdid_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rdid_ctrl.sv
// rdid_ctrl: SPI mode-0 master that issues the JEDEC Read-ID opcode to a
// serial flash and captures the returned ID bytes.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     level-sampled request, accepted only in IDLE
//   busy      high from acceptance to the end of DONE
//   done      one-cycle pulse; id_data valid from this cycle on
//   id_data   captured ID, first received byte in the MSBs
//   spi_cs_n  chip select, active low
//   spi_sclk  SPI clock, idles low
//   spi_mosi  command data, MSB first
//   spi_miso  flash data out
//
// Optional feature macro: AUTO_RDID_EN -- when defined, one transaction is
// issued automatically STARTUP_CYCLES cycles after every reset release.
module rdid_ctrl #(
    parameter int          CLK_DIV        = 4,
    parameter int          ID_BYTES       = 3,
    parameter logic [7:0]  CMD            = 8'h9F,
    parameter int          STARTUP_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [8*ID_BYTES-1:0]   id_data,
    output logic                    spi_cs_n,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam int NBITS = 8 * (1 + ID_BYTES);
    localparam int HW    = $clog2(CLK_DIV);
    localparam int BW    = $clog2(NBITS + 1);
    localparam int SW    = 8 * ID_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [BW-1:0]   bcnt;
    logic [SW-1:0]   shreg;
    logic [BW-1:0]   nxt_bit;
    logic            nxt_mosi;
    logic            half_end;
    logic            go;

    assign half_end = (hcnt == HW'(CLK_DIV - 1));

    // MOSI value for the bit following the current one: command bits, then 0.
    always_comb begin
        nxt_bit  = bcnt + BW'(1);
        nxt_mosi = 1'b0;
        if (nxt_bit < BW'(8))
            nxt_mosi = CMD[3'(BW'(7) - nxt_bit)];
    end

`ifdef AUTO_RDID_EN
    localparam int UW = $clog2(STARTUP_CYCLES + 1);
    logic [UW-1:0] su_cnt;
    logic          auto_pend;
    logic          auto_go;

    assign auto_go = auto_pend && (su_cnt == UW'(STARTUP_CYCLES - 1));
    assign go      = (state == IDLE) && (start || auto_go);

    // Startup countdown; any acceptance (start or auto) retires the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            su_cnt    <= '0;
            auto_pend <= 1'b1;
        end else if (go) begin
            auto_pend <= 1'b0;
        end else if (auto_pend && state == IDLE) begin
            su_cnt <= su_cnt + UW'(1);
        end
    end
`else
    assign go = (state == IDLE) && start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            id_data  <= '0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= CS_SETUP;
                        hcnt     <= '0;
                        bcnt     <= '0;
                        shreg    <= '0;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= CMD[7];
                    end
                end
                CS_SETUP: begin
                    hcnt <= hcnt + HW'(1);
                    if (half_end) begin
                        hcnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    hcnt <= hcnt + HW'(1);
                    if (half_end) begin
                        hcnt <= '0;
                        if (!spi_sclk) begin
                            // Rising SCLK edge: sample MISO; command-phase bits are dropped.
                            spi_sclk <= 1'b1;
                            if (bcnt >= BW'(8))
                                shreg <= {shreg[SW-2:0], spi_miso};
                        end else begin
                            // Falling SCLK edge: advance to the next bit.
                            spi_sclk <= 1'b0;
                            if (bcnt == BW'(NBITS - 1)) begin
                                state    <= CS_HOLD;
                                spi_mosi <= 1'b0;
                            end else begin
                                bcnt     <= nxt_bit;
                                spi_mosi <= nxt_mosi;
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    hcnt <= hcnt + HW'(1);
                    if (half_end) begin
                        hcnt     <= '0;
                        state    <= DONE;
                        spi_cs_n <= 1'b1;
                        done     <= 1'b1;
                        id_data  <= shreg;
                    end
                end
                DONE: begin
                    hcnt <= hcnt + HW'(1);
                    if (half_end) begin
                        hcnt  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
